// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paces the ball from the frame tick, raises the
// registered bounce pulses for the ball block, detects misses, keeps the
// scores and walks the serve -> play -> point -> game-over flow.
module pong_game_ctrl #(
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SZ      = 8,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int STEP_DIV     = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [X_W-1:0]     ball_x,
  input  logic [Y_W-1:0]     ball_y,
  input  logic [Y_W-1:0]     pad_l_y,
  input  logic [Y_W-1:0]     pad_r_y,
  output logic               ball_step,
  output logic               ball_load,
  output logic [X_W-1:0]     serve_x,
  output logic [Y_W-1:0]     serve_y,
  output logic               ball_reset,
  output logic               touching_paddle,
  output logic               touching_wall,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               game_over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int XE_W     = X_W + 1;
  localparam int YE_W     = Y_W + 1;
  localparam int STEP_CW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SERVE_CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [STEP_CW-1:0]  STEP_LAST  = STEP_CW'(STEP_DIV - 1);
  localparam logic [SERVE_CW-1:0] SERVE_LAST = SERVE_CW'(SERVE_FRAMES - 1);
  localparam logic [X_W-1:0]      X_MAX      = X_W'(SCREEN_W - BALL_SZ);
  localparam logic [Y_W-1:0]      Y_MAX      = Y_W'(SCREEN_H - BALL_SZ);
  localparam logic [X_W-1:0]      PAD_L_FACE = X_W'(PAD_L_X + PAD_W);
  localparam logic [XE_W-1:0]     PAD_R_FACE = XE_W'(PAD_R_X);
  localparam logic [XE_W-1:0]     BALL_SZ_X  = XE_W'(BALL_SZ);
  localparam logic [YE_W-1:0]     BALL_SZ_Y  = YE_W'(BALL_SZ);
  localparam logic [YE_W-1:0]     PAD_H_Y    = YE_W'(PAD_H);
  localparam logic [SCORE_W-1:0]  WIN        = SCORE_W'(WIN_SCORE);

  state_e               state_q, state_d;
  logic [STEP_CW-1:0]   step_cnt_q, step_cnt_d;
  logic [SERVE_CW-1:0]  serve_cnt_q, serve_cnt_d;
  logic                 dir_x_q, dir_x_d;
  logic                 dir_y_q, dir_y_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic                 ball_step_q, ball_step_d;
  logic                 ball_reset_q, ball_reset_d;
  logic                 touch_pad_q, touch_pad_d;
  logic                 touch_wall_q, touch_wall_d;
  logic                 go_serve;

  // Geometry is widened by one bit so ball/paddle bottoms never wrap.
  logic [XE_W-1:0] ball_right;
  logic [YE_W-1:0] ball_top, ball_bot;
  logic [YE_W-1:0] pad_l_top, pad_l_bot, pad_r_top, pad_r_bot;
  logic            miss_l, miss_r, hit_pad_l, hit_pad_r, hit_wall;

  assign ball_right = {1'b0, ball_x} + BALL_SZ_X;
  assign ball_top   = {1'b0, ball_y};
  assign ball_bot   = ball_top + BALL_SZ_Y;
  assign pad_l_top  = {1'b0, pad_l_y};
  assign pad_l_bot  = pad_l_top + PAD_H_Y;
  assign pad_r_top  = {1'b0, pad_r_y};
  assign pad_r_bot  = pad_r_top + PAD_H_Y;

  // Hits only count when the ball is heading into the surface, so a ball
  // that has just bounced is not flipped back on the following step.
  assign miss_l    = ~dir_x_q & (ball_x == '0);
  assign miss_r    =  dir_x_q & (ball_x == X_MAX);
  assign hit_pad_l = ~dir_x_q & (ball_x == PAD_L_FACE) &
                     (ball_bot > pad_l_top) & (ball_top < pad_l_bot);
  assign hit_pad_r =  dir_x_q & (ball_right == PAD_R_FACE) &
                     (ball_bot > pad_r_top) & (ball_top < pad_r_bot);
  assign hit_wall  = (~dir_y_q & (ball_y == '0)) | (dir_y_q & (ball_y == Y_MAX));

  // Next-state logic: game flow, frame pacing, step evaluation and scoring.
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    serve_cnt_d  = serve_cnt_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    ball_step_d  = 1'b0;
    ball_reset_d = 1'b0;
    touch_pad_d  = 1'b0;
    touch_wall_d = 1'b0;
    go_serve     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) go_serve = 1'b1;
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d    = ST_PLAY;
            step_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            if (miss_l) begin
              score_r_d = (score_r_q == WIN) ? WIN : score_r_q + 1'b1;
              state_d   = ST_POINT;
            end else if (miss_r) begin
              score_l_d = (score_l_q == WIN) ? WIN : score_l_q + 1'b1;
              state_d   = ST_POINT;
            end else begin
              ball_step_d = 1'b1;
              if (hit_pad_l | hit_pad_r) begin
                touch_pad_d = 1'b1;
                dir_x_d     = ~dir_x_q;
              end
              if (hit_wall) begin
                touch_wall_d = 1'b1;
                dir_y_d      = ~dir_y_q;
              end
            end
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      ST_POINT: begin
        if ((score_l_q == WIN) || (score_r_q == WIN)) state_d = ST_OVER;
        else go_serve = 1'b1;
      end
      ST_OVER: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          go_serve  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every entry into SERVE resyncs the ball block's signs with ours.
    if (go_serve) begin
      state_d      = ST_SERVE;
      serve_cnt_d  = '0;
      ball_reset_d = 1'b1;
      dir_x_d      = 1'b0;
      dir_y_d      = 1'b0;
    end
  end

  // State and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_cnt_q   <= '0;
      serve_cnt_q  <= '0;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      ball_step_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      touch_pad_q  <= 1'b0;
      touch_wall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      serve_cnt_q  <= serve_cnt_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      ball_step_q  <= ball_step_d;
      ball_reset_q <= ball_reset_d;
      touch_pad_q  <= touch_pad_d;
      touch_wall_q <= touch_wall_d;
    end
  end

  // Pulses are masked while reset is held so nothing leaks out in that cycle.
  assign ball_step       = ball_step_q  & ~reset;
  assign ball_reset      = ball_reset_q & ~reset;
  assign touching_paddle = touch_pad_q  & ~reset;
  assign touching_wall   = touch_wall_q & ~reset;

  assign ball_load = reset || (state_q == ST_IDLE) || (state_q == ST_SERVE) ||
                     (state_q == ST_OVER);
  assign game_over = (state_q == ST_OVER);
  assign state     = state_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serve_x   = X_W'((SCREEN_W - BALL_SZ) / 2);
  assign serve_y   = Y_W'((SCREEN_H - BALL_SZ) / 2);

endmodule
